// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory port between fetch reads and loader writes,
// sequencing each access IDLE -> ISSUE -> WAIT -> RESP through a fixed-latency memory.
module imem_port_arbiter #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  input  logic        pc_select_execute,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic        mem_en,
  output logic        mem_rd_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0]  LAT_C      = 3'(MEM_LAT);
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        owner_fetch_q, owner_fetch_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        squash_q, squash_d;
  logic [31:0] instr_q, instr_d;

  logic idle_ok;
  logic ld_wins;

  // Grants are combinational in IDLE and held off while reset is asserted.
  always_comb begin
    idle_ok   = (state_q == ST_IDLE) && rst;
    ld_wins   = ld_req && (!fetch_req || (wait_cnt_q == MAX_WAIT_C));
    fetch_gnt = idle_ok && fetch_req && !ld_wins;
    ld_gnt    = idle_ok && ld_wins;
  end

  always_comb begin
    state_d       = state_q;
    owner_fetch_d = owner_fetch_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lat_cnt_d     = lat_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    squash_d      = squash_q;
    instr_d       = instr_q;

    if (!ld_req || ld_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (fetch_gnt && (wait_cnt_q != MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (pc_select_execute && (fetch_gnt || ((state_q != ST_IDLE) && owner_fetch_q))) begin
      squash_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fetch_gnt) begin
          owner_fetch_d = 1'b1;
          addr_d        = fetch_addr & WORD_MASK;
          state_d       = ST_ISSUE;
        end else if (ld_gnt) begin
          owner_fetch_d = 1'b0;
          addr_d        = ld_addr & WORD_MASK;
          wdata_d       = ld_data;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_d = LAT_C;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Read data is valid in the last WAIT cycle, so it is captured here and
        // is already on fetch_instr when fetch_valid pulses in RESP.
        if (lat_cnt_q <= 3'd1) begin
          if (owner_fetch_q) begin
            instr_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        squash_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      owner_fetch_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lat_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      squash_q      <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lat_cnt_q     <= lat_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      squash_q      <= squash_d;
      instr_q       <= instr_d;
    end
  end

  // A redirect arriving in the RESP cycle itself still suppresses the pulse.
  always_comb begin
    mem_en      = (state_q == ST_ISSUE);
    mem_rd_wr   = owner_fetch_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    fetch_instr = instr_q;
    fetch_valid = (state_q == ST_RESP) && owner_fetch_q && !squash_q && !pc_select_execute;
    ld_done     = (state_q == ST_RESP) && !owner_fetch_q;
  end

endmodule
